// File: rtl/sequence_player.sv
// sequence_player: Simon Says sequence generator and timed playback with comparator pass strobes.
// Define SEQ_PLAYER_FIXED_SEQ_EN for the deterministic 0,1,2,3,... direction sequence.
module sequence_player #(
    parameter int          MAX_LEN    = 16,
    parameter int          ON_CYCLES  = 25000000,
    parameter int          OFF_CYCLES = 12500000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          LW         = $clog2(MAX_LEN + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          next_round,
    output logic [1:0]    direction_out,
    output logic          direction_valid,
    output logic          pass_signal,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] length,
    output logic          full
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int TW = $clog2((ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES) + 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] APPEND = 3'd1;
    localparam logic [2:0] SHOW   = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]               state;
    logic [MAX_LEN-1:0][1:0]  seq;
    logic [IW-1:0]            idx;
    logic [TW-1:0]            timer;
    logic [15:0]              lfsr;
    logic [1:0]               new_dir;
    logic                     show_end;
    logic                     gap_end;
    logic                     last;

    // Free-running so the game seed depends on when the player presses start
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

`ifdef SEQ_PLAYER_FIXED_SEQ_EN
    assign new_dir = length[1:0];
`else
    assign new_dir = lfsr[1:0];
`endif

    assign show_end = timer == TW'(ON_CYCLES - 1);
    assign gap_end  = timer == TW'(OFF_CYCLES - 1);
    assign last     = LW'(idx) == length - LW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            length <= '0;
            idx    <= '0;
            seq    <= '0;
            timer  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (start) begin
                        length <= '0;
                        seq    <= '0;
                        state  <= APPEND;
                    end else if (next_round && full)
                        state <= SHOW;
                    else if (next_round && length != '0)
                        state <= APPEND;
                end
                APPEND: begin
                    seq[length[IW-1:0]] <= new_dir;
                    length <= length + 1'b1;
                    idx    <= '0;
                    timer  <= '0;
                    state  <= SHOW;
                end
                SHOW: begin
                    timer <= show_end ? '0 : timer + 1'b1;
                    if (show_end)
                        state <= GAP;
                end
                GAP: begin
                    timer <= gap_end ? '0 : timer + 1'b1;
                    if (gap_end && last)
                        state <= DONE;
                    else if (gap_end) begin
                        idx   <= idx + 1'b1;
                        state <= SHOW;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy            = state != IDLE;
    assign done            = state == DONE;
    assign direction_valid = state == SHOW;
    assign pass_signal     = state == SHOW && timer == '0;
    assign direction_out   = (state == SHOW || state == GAP) ? seq[idx] : 2'd0;
    assign full            = length == LW'(MAX_LEN);
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: randomized self-checking bench against a cycle-timeline reference model.
module tb_sequence_player;
    localparam int ML  = 4;
    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int P   = ON + OFF;

    logic       clock = 0;
    logic       reset = 1;
    logic       start = 0;
    logic       next_round = 0;
    logic [1:0] direction_out;
    logic       direction_valid;
    logic       pass_signal;
    logic       busy;
    logic       done;
    logic [2:0] length;
    logic       full;

    int passed = 0;
    int total = 0;

    logic [15:0] m_lfsr;
    logic [1:0]  m_seq[$];

    sequence_player #(.MAX_LEN(ML), .ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
        .clock(clock), .reset(reset), .start(start), .next_round(next_round),
        .direction_out(direction_out), .direction_valid(direction_valid),
        .pass_signal(pass_signal), .busy(busy), .done(done),
        .length(length), .full(full)
    );

    always #5 clock = ~clock;

    // Reference Galois LFSR: shift right, xor taps when the bit shifted out is 1
    always @(posedge clock or posedge reset)
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic play(input bit do_start, input bit do_next);
        bit act, app, e_busy, e_valid, e_pass, e_done, in_play;
        logic [1:0] nd, e_dir;
        int n, base, done_c, last_c, rel, k;
        act = do_start || (do_next && m_seq.size() > 0);
        app = do_start || (do_next && m_seq.size() > 0 && m_seq.size() < ML);
        if (do_start) m_seq.delete();
        start = do_start;
        next_round = do_next;
        tick;
        start = 0;
        next_round = 0;
        if (app) begin
`ifdef SEQ_PLAYER_FIXED_SEQ_EN
            nd = 2'(m_seq.size());
`else
            nd = m_lfsr[1:0];
`endif
            m_seq.push_back(nd);
        end
        n = m_seq.size();
        base = app ? 2 : 1;
        done_c = act ? base + n * P : 0;
        last_c = act ? done_c + 2 : 10;
        for (int c = 1; c <= last_c; c++) begin
            if (c > 1) tick;
            rel = c - base;
            in_play = act && rel >= 0 && rel < n * P;
            k = in_play ? rel / P : 0;
            e_busy = act && c <= done_c;
            e_valid = in_play && (rel % P) < ON;
            e_pass = in_play && (rel % P) == 0;
            e_done = act && c == done_c;
            e_dir = 2'd0;
            if (in_play) e_dir = m_seq[k];
            total++;
            if (busy !== e_busy) $display("FAIL busy cycle %0d: got %b want %b", c, busy, e_busy);
            else passed++;
            total++;
            if (direction_valid !== e_valid) $display("FAIL direction_valid cycle %0d: got %b want %b", c, direction_valid, e_valid);
            else passed++;
            total++;
            if (pass_signal !== e_pass) $display("FAIL pass_signal cycle %0d: got %b want %b", c, pass_signal, e_pass);
            else passed++;
            total++;
            if (direction_out !== e_dir) $display("FAIL direction_out cycle %0d: got %0d want %0d", c, direction_out, e_dir);
            else passed++;
            total++;
            if (done !== e_done) $display("FAIL done cycle %0d: got %b want %b", c, done, e_done);
            else passed++;
        end
        total++;
        if (length !== 3'(m_seq.size())) $display("FAIL length: got %0d want %0d", length, m_seq.size());
        else passed++;
        total++;
        if (full !== (m_seq.size() == ML)) $display("FAIL full: got %b want %b", full, m_seq.size() == ML);
        else passed++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick;
    endtask

    task automatic do_reset;
        reset = 1;
        m_seq.delete();
        tick;
        reset = 0;
    endtask

    task automatic test_reset;
        do_reset;
        total++;
        if ({direction_out, direction_valid, pass_signal, busy, done, length, full} !== 10'd0)
            $display("FAIL reset outputs: got %b want 0", {direction_out, direction_valid, pass_signal, busy, done, length, full});
        else passed++;
    endtask

    task automatic test_first_round;
        play(1, 0);
    endtask

    task automatic test_fill;
        for (int r = 0; r < 3; r++) begin
            idle($urandom_range(0, 5));
            play(0, 1);
        end
    endtask

    task automatic test_full_replay;
        idle($urandom_range(0, 3));
        play(0, 1);
    endtask

    task automatic test_ignore_and_priority;
        do_reset;
        idle($urandom_range(0, 3));
        play(0, 1);
        play(1, 1);
    endtask

    task automatic test_reset_abort;
        do_reset;
        play(1, 0);
        play(0, 1);
        next_round = 1;
        tick;
        next_round = 0;
        idle(7);
        total++;
        if (direction_valid !== 1'b1) $display("FAIL abort_setup: got valid %b want 1", direction_valid);
        else passed++;
        reset = 1;
        m_seq.delete();
        #1;
        total++;
        if ({direction_out, direction_valid, pass_signal, busy, done, length, full} !== 10'd0)
            $display("FAIL abort outputs: got %b want 0", {direction_out, direction_valid, pass_signal, busy, done, length, full});
        else passed++;
        tick;
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            total++;
            if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_quiet: got done %b busy %b want 0 0", done, busy);
            else passed++;
        end
        play(1, 0);
    endtask

    task automatic test_random;
        int r;
        for (int it = 0; it < 20; it++) begin
            idle($urandom_range(0, 7));
            r = $urandom_range(0, 4);
            play(r == 0 || r == 1, r != 0);
        end
    endtask

    initial begin
        test_reset;
        test_first_round;
        test_fill;
        test_full_replay;
        test_ignore_and_priority;
        test_reset_abort;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sequence_player.md
# sequence_player

Producer end of the Simon Says direction path. The block generates the game's random sequence of 2-bit arrow directions and stores up to `MAX_LEN` of them. On each round it appends one new direction, then plays the whole sequence out oldest-first with timed on/off display. For each element it emits a one-cycle `pass_signal` with `direction_out`, so the comparator shift chain can load the expected sequence while the player watches.

## Interface
- `MAX_LEN`, 16: maximum sequence length; must be ≥2.
- `ON_CYCLES`, 25000000: cycles each arrow is lit; must be ≥1.
- `OFF_CYCLES`, 12500000: dark cycles after each arrow; must be ≥1.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `LW`, $clog2(MAX_LEN+1): width of `length`. Derived; not overridden.

- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  pulse: begin a new game.
- `next_round`  in  1  pulse: append one direction and replay.
- `direction_out`  out  2  current direction: 0 up, 1 right, 2 down, 3 left.
- `direction_valid`  out  1  arrow lit (SHOW phase).
- `pass_signal`  out  1  one-cycle strobe; comparator loads `direction_out`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when playback finishes.
- `length`  out  LW  number of stored directions.
- `full`  out  1  `length == MAX_LEN`.

## Operation
- Storage: `2*MAX_LEN`-bit register. Element i sits at bits `[2i+1:2i]`; index 0 is the oldest.
- LFSR: 16-bit Galois, taps 16'hB400. Shifts every cycle from reset, so the game seed depends on player timing. The new direction is `lfsr[1:0]`, sampled in APPEND.
- FSM states: IDLE, APPEND, SHOW, GAP, DONE.
- **IDLE**
  - `start`: clear `length` to 0, then go to APPEND.
  - `next_round` with `length` > 0 and not `full`: go to APPEND.
  - `next_round` with `full`: go straight to SHOW, replaying without appending.
  - `next_round` with `length == 0`: ignored.
  - `start` and `next_round` together: `start` wins.
- **APPEND**: write the new direction at index `length`, increment `length`, reset the playback index to 0, go to SHOW.
- **SHOW**
  - `direction_valid = 1` for exactly `ON_CYCLES` cycles.
  - `pass_signal = 1` only in the first SHOW cycle of each element.
  - Then go to GAP.
- **GAP**
  - `direction_valid = 0` for exactly `OFF_CYCLES` cycles.
  - Then, if index == `length-1`, go to DONE; otherwise increment the index and go to SHOW.
- **DONE**: `done = 1` for one cycle, then go to IDLE.
- `direction_out` shows the element at the current index during SHOW and GAP; it is 0 in IDLE, APPEND and DONE.
- `start` and `next_round` are ignored while `busy`.
- The stored sequence is preserved across rounds; only `start` or `reset` clears it.

## Timing
- Reset values:
  - state IDLE, `length` 0, playback index 0, storage 0, LFSR `LFSR_SEED`, timer 0.
  - `direction_out` 0, `direction_valid` 0, `pass_signal` 0, `busy` 0, `done` 0, `full` 0.
- Reset asserted mid-playback forces all of the above on the next evaluation, with no completion pulse. An aborted round leaves no residue.
- Latency: a command sampled at edge 0 gives APPEND in cycle 1 and the first SHOW cycle in cycle 2. `busy` rises in cycle 1.
- A full-sequence replay (no append) enters SHOW in cycle 1.
- Playback duration for N elements: `N*(ON_CYCLES+OFF_CYCLES)` cycles, followed by one DONE cycle.
- `pass_signal` pulses are exactly `ON_CYCLES+OFF_CYCLES` cycles apart.
- Wrap-around: the timer counts 0..limit-1 and reloads to 0 on each phase change. The playback index never exceeds `length-1`.

## Configuration
- `SEQ_PLAYER_FIXED_SEQ_EN` defined: the appended direction is `length[1:0]` before the increment, giving the deterministic sequence 0,1,2,3,0,1,… The LFSR is still instantiated but unused. This mode is for simulation and board bring-up.
- Not defined: directions come from `lfsr[1:0]` as described in Operation.

## Test plan
All scenarios use `SEQ_PLAYER_FIXED_SEQ_EN`, `ON_CYCLES=4`, `OFF_CYCLES=2`, `MAX_LEN=4`.
1. `start` pulse at cycle 0 -> `busy` in cycles 1–8; `pass_signal` only in cycle 2 with `direction_out=0`; `direction_valid` in cycles 2–5; `done` in cycle 8; `length=1`.
2. After scenario 1, three `next_round` pulses, each issued after `done` -> final playback gives `pass_signal` with `direction_out` 0,1,2,3, spaced 6 cycles apart; `length=4`; `full=1`.
3. At `full`, `next_round` -> SHOW entered in cycle 1; same four directions; `length` stays 4; `done` in cycle 25.
4. `next_round` after reset with `length=0` -> `busy` stays 0 and no `pass_signal`. `start` and `next_round` in the same cycle -> `length=1` (start behaviour).
5. `reset` asserted during the second SHOW of a 3-element playback -> all outputs 0 immediately; no `done`; a following `start` yields `length=1`, first direction 0.
6. Without the macro, `start` -> the stored direction equals the `lfsr[1:0]` value in the APPEND cycle, as predicted by a bench LFSR model seeded with 16'hACE1.
